ram_access_arbiter: RTL and testbench

- Shares the single-port command RAM between two local requesters.
- Converts each atomic request (read or write) into the RAM's two-word command sequence: address word, then data word.
- For reads, waits for the RAM's read-valid strobe and returns the data with an ack.
- Sits between the RAM instance and on-chip masters such as the SPI slave path and a local host/BIST engine.

---
 rtl/ram_access_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_ram_access_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//   Shares the single-port command RAM between two local requesters. Each
//   atomic read or write becomes a two-word command sequence: an address word,
//   then a data word. A read then waits for the RAM's read-valid strobe. Two
//   simultaneous requesters are served round-robin.
//
//   Optional feature macro: RAM_ARB_RD_TIMEOUT_EN
//     When defined, this adds parameter RD_TIMEOUT and output err. A read that
//     sees no ram_tx_valid for RD_TIMEOUT wait cycles completes with rdata=0
//     and err=1.
//
//   Ports
//     clk, rst             rising-edge clock, synchronous active-high reset
//     req0/wr0/addr0/wdata0 port 0 request (held until ack0), op, address, data
//     ack0                  port 0 completion, one-cycle pulse
//     req1/wr1/addr1/wdata1 port 1, same as port 0
//     ack1                  port 1 completion, one-cycle pulse
//     rdata                 read data, valid while the read's ack is high
//     ram_din               command word to RAM {cmd[1:0], payload}
//     ram_rx_valid          command word strobe to RAM
//     ram_dout              RAM read data
//     ram_tx_valid          RAM read data valid
//     err                   (feature only) read timed out, alongside ack
module ram_access_arbiter #(
  parameter int unsigned DW = 8
`ifdef RAM_ARB_RD_TIMEOUT_EN
  ,
  parameter int unsigned RD_TIMEOUT = 15
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          wr0,
  input  logic [DW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [DW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [DW+1:0] ram_din,
  output logic          ram_rx_valid,
  input  logic [DW-1:0] ram_dout,
  input  logic          ram_tx_valid
`ifdef RAM_ARB_RD_TIMEOUT_EN
  ,
  output logic          err
`endif
);

  localparam int unsigned CW = DW + 2;

  // Command codes carried in the top two bits of the RAM command word
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

`ifdef RAM_ARB_RD_TIMEOUT_EN
  // The counter runs 0..RD_TIMEOUT-1 while in WAIT_RD
  localparam int unsigned TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD_ADDR = 3'd1,
    CMD_DATA = 3'd2,
    WAIT_RD  = 3'd3,
    RESP     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            gnt_q, gnt_d;       // granted port index
  logic            ptr_q, ptr_d;       // favoured port when both request
  logic            wr_q, wr_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]   din_q, din_d;
  logic            rxv_q, rxv_d;
  logic            sel_c;
`ifdef RAM_ARB_RD_TIMEOUT_EN
  logic            err_q, err_d;
  logic [TW-1:0]   cnt_q, cnt_d;
`endif

  // Grant choice: a lone requester wins, otherwise the favoured port
  assign sel_c = (req0 && req1) ? ptr_q : req1;

  // Next-state and next-output logic. Outputs are registered from the value
  // they must carry in the next state, so they line up with that state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rdata_d = rdata_q;
    din_d   = '0;
    rxv_d   = 1'b0;
`ifdef RAM_ARB_RD_TIMEOUT_EN
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = sel_c;
          wr_d    = sel_c ? wr1    : wr0;
          addr_d  = sel_c ? addr1  : addr0;
          wdata_d = sel_c ? wdata1 : wdata0;
          state_d = CMD_ADDR;
          rxv_d   = 1'b1;
          din_d   = {(wr_d ? CMD_WR_ADDR : CMD_RD_ADDR), addr_d};
        end
      end

      CMD_ADDR: begin
        state_d = CMD_DATA;
        rxv_d   = 1'b1;
        din_d   = wr_q ? {CMD_WR_DATA, wdata_q} : {CMD_RD_DATA, {DW{1'b0}}};
      end

      CMD_DATA: begin
        if (wr_q) begin
          state_d = RESP;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end else begin
          state_d = WAIT_RD;
`ifdef RAM_ARB_RD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      WAIT_RD: begin
        if (ram_tx_valid) begin
          rdata_d = ram_dout;
          state_d = RESP;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
`ifdef RAM_ARB_RD_TIMEOUT_EN
        end else if (cnt_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end else begin
          cnt_d   = cnt_q + TW'(1);
`endif
        end
      end

      RESP: begin
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
      din_q   <= '0;
      rxv_q   <= 1'b0;
`ifdef RAM_ARB_RD_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
      din_q   <= din_d;
      rxv_q   <= rxv_d;
`ifdef RAM_ARB_RD_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign rdata        = rdata_q;
  assign ram_din      = din_q;
  assign ram_rx_valid = rxv_q;
`ifdef RAM_ARB_RD_TIMEOUT_EN
  assign err          = err_q;
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
//   Scoreboard bench for ram_access_arbiter. A behavioural RAM decodes the
//   command words, stores writes and answers reads two cycles after the read
//   data word. Expected command words and acks are queued when a request is
//   driven and compared by a monitor when the DUT produces them.
module tb_ram_access_arbiter;

  localparam int unsigned DW = 8;

  typedef struct packed {
    logic          port;
    logic          rd;
    logic [DW-1:0] data;
    logic          err;
  } ack_t;

  logic          clk;
  logic          rst;
  logic          req0, wr0, req1, wr1;
  logic [DW-1:0] addr0, wdata0, addr1, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata;
  logic [DW+1:0] ram_din;
  logic          ram_rx_valid;
  logic [DW-1:0] ram_dout;
  logic          ram_tx_valid;
`ifdef RAM_ARB_RD_TIMEOUT_EN
  logic          err;
`endif

  ram_access_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .wr0          (wr0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .ack0         (ack0),
    .req1         (req1),
    .wr1          (wr1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .ack1         (ack1),
    .rdata        (rdata),
    .ram_din      (ram_din),
    .ram_rx_valid (ram_rx_valid),
    .ram_dout     (ram_dout),
    .ram_tx_valid (ram_tx_valid)
`ifdef RAM_ARB_RD_TIMEOUT_EN
    ,
    .err          (err)
`endif
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            tx_cyc   = 0;
  logic [DW+1:0] exp_cmd[$];
  ack_t          exp_ack[$];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ram_mem [256];
  logic [DW-1:0] exp_rdata = '0;
  bit            inject_tx   = 1'b0;
  bit            ram_respond = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural RAM: decodes command words, answers reads after two cycles
  initial begin : ram_model
    int            rd_cnt;
    logic [DW-1:0] wa, ra;
    rd_cnt       = 0;
    wa           = '0;
    ra           = '0;
    ram_tx_valid = 1'b0;
    ram_dout     = '0;
    forever begin
      @(negedge clk);
      ram_tx_valid = 1'b0;
      if (rst) rd_cnt = 0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          ram_tx_valid = 1'b1;
          ram_dout     = ram_mem[ra];
          tx_cyc       = cyc;
        end
      end
      if (inject_tx) begin
        inject_tx    = 1'b0;
        ram_tx_valid = 1'b1;
        ram_dout     = 8'hEE;
      end
      if (ram_rx_valid) begin
        case (ram_din[DW+1:DW])
          2'b00:   wa = ram_din[DW-1:0];
          2'b01:   ram_mem[wa] = ram_din[DW-1:0];
          2'b10:   ra = ram_din[DW-1:0];
          default: if (ram_respond) rd_cnt = 2;
        endcase
      end
    end
  end

  // Monitor: pops the scoreboard on every strobe and every ack
  always @(negedge clk) begin : monitor
    ack_t          ea;
    logic [DW+1:0] ec;
    if (ram_rx_valid) begin
      if (exp_cmd.size() == 0) begin
        check_eq("cmd_q_nonempty", 32'(exp_cmd.size()), 32'd1);
      end else begin
        ec = exp_cmd.pop_front();
        check_eq("ram_din", 32'(ram_din), 32'(ec));
      end
    end
    if (ack0 || ack1) begin
      check_eq("ack_overlap", 32'(ack0 && ack1), 32'd0);
      if (exp_ack.size() == 0) begin
        check_eq("ack_q_nonempty", 32'(exp_ack.size()), 32'd1);
      end else begin
        ea = exp_ack.pop_front();
        check_eq("ack_port", 32'(ack1), 32'(ea.port));
        if (ea.rd) begin
          check_eq("rdata", 32'(rdata), 32'(ea.data));
          exp_rdata = ea.data;
        end
`ifdef RAM_ARB_RD_TIMEOUT_EN
        check_eq("err", 32'(err), 32'(ea.err));
`endif
      end
    end
`ifdef RAM_ARB_RD_TIMEOUT_EN
    else check_eq("err_idle", 32'(err), 32'd0);
`endif
    if (rst) exp_rdata = '0;
    else check_eq("rdata_hold", 32'(rdata), 32'(exp_rdata));
  end

  // Queue the command words and the ack a request should produce
  task automatic push_txn(input logic port, input logic wr, input logic [DW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic tmo);
    ack_t a;
    exp_cmd.push_back({(wr ? 2'b00 : 2'b10), addr});
    exp_cmd.push_back(wr ? {2'b01, wdata} : {2'b11, 8'h00});
    a.port = port;
    a.rd   = ~wr;
    a.err  = tmo;
    if (wr) begin
      ref_mem[addr] = wdata;
      a.data = '0;
    end else begin
      a.data = tmo ? 8'h00 : ref_mem[addr];
    end
    exp_ack.push_back(a);
  endtask

  task automatic drive_req(input logic port, input logic wr, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata);
    if (port) begin
      req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wdata;
    end
  endtask

  task automatic drop_req(input logic port);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  task automatic wait_ack(input logic port, output int ack_cyc);
    ack_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((port ? ack1 : ack0) === 1'b1) begin
        ack_cyc = cyc;
        break;
      end
    end
    if (ack_cyc < 0) check_eq(port ? "ack1_wait" : "ack0_wait", 32'(port ? ack1 : ack0), 32'd1);
  endtask

  // Single transaction from idle with latency check
  task automatic do_txn(input logic port, input logic wr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata);
    int t0, ac;
    push_txn(port, wr, addr, wdata, 1'b0);
    drive_req(port, wr, addr, wdata);
    t0 = cyc;
    wait_ack(port, ac);
    drop_req(port);
    if (wr) check_eq("wr_lat", 32'(ac - t0), 32'd3);
    else    check_eq("rd_lat", 32'(ac - tx_cyc), 32'd1);
  endtask

  // Keeps req high through each ack, presenting the next write straight away
  task automatic run_port_stream(input logic port, input int n);
    int ac;
    for (int i = 0; i < n; i++) begin
      drive_req(port, 1'b1, port ? 8'(8'h30 + i) : 8'(8'h20 + i),
                port ? 8'(8'h50 + i) : 8'(8'h40 + i));
      wait_ack(port, ac);
    end
    drop_req(port);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    bit found;
    int t0, ac;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'(i * 7 + 3);
      ram_mem[i] = 8'(i * 7 + 3);
    end
    rst = 1'b1;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_ack0", 32'(ack0), 32'd0);
    check_eq("rst_ack1", 32'(ack1), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_eq("rst_ram_din", 32'(ram_din), 32'd0);
    check_eq("rst_rx_valid", 32'(ram_rx_valid), 32'd0);
`ifdef RAM_ARB_RD_TIMEOUT_EN
    check_eq("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Port 0 write 0x12 <- 0xA5
    do_txn(1'b0, 1'b1, 8'h12, 8'hA5);
    @(negedge clk);

    // Port 1 read 0x12
    do_txn(1'b1, 1'b0, 8'h12, 8'h00);
    check_eq("rd1_data", 32'(rdata), 32'hA5);
    @(negedge clk);
    check_eq("ack1_pulse", 32'(ack1), 32'd0);

    // Both ports streaming writes from reset: 0,1,0,1,0,1
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_txn(1'b0, 1'b1, 8'(8'h20 + i), 8'(8'h40 + i), 1'b0);
      push_txn(1'b1, 1'b1, 8'(8'h30 + i), 8'(8'h50 + i), 1'b0);
    end
    fork
      run_port_stream(1'b0, 3);
      run_port_stream(1'b1, 3);
    join
    @(negedge clk);
    check_eq("arb_ack_q_drained", 32'(exp_ack.size()), 32'd0);

    // Reset while a write is in CMD_DATA
    exp_cmd.push_back({2'b00, 8'h44});
    exp_cmd.push_back({2'b01, 8'h77});
    ref_mem[8'h44] = 8'h77;
    drive_req(1'b0, 1'b1, 8'h44, 8'h77);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ram_rx_valid && ram_din[DW+1:DW] == 2'b01) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("rst_reach_cmd_data", 32'(found), 32'd1);
    rst = 1'b1;
    drop_req(1'b0);
    @(negedge clk);
    check_eq("midrst_rx_valid", 32'(ram_rx_valid), 32'd0);
    check_eq("midrst_ack0", 32'(ack0), 32'd0);
    check_eq("midrst_ram_din", 32'(ram_din), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_txn(1'b1, 1'b1, 8'h45, 8'h3C);
    @(negedge clk);
    do_txn(1'b1, 1'b0, 8'h45, 8'h00);
    check_eq("post_rst_rd", 32'(rdata), 32'h3C);
    @(negedge clk);

    // Spurious ram_tx_valid in IDLE and during a write
    do_txn(1'b0, 1'b0, 8'h12, 8'h00);
    @(negedge clk);
    inject_tx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_tx_rdata", 32'(rdata), 32'hA5);
    push_txn(1'b1, 1'b1, 8'h55, 8'h66, 1'b0);
    drive_req(1'b1, 1'b1, 8'h55, 8'h66);
    @(negedge clk);
    inject_tx = 1'b1;
    wait_ack(1'b1, ac);
    drop_req(1'b1);
    check_eq("wr_tx_rdata", 32'(rdata), 32'hA5);
    @(negedge clk);

`ifdef RAM_ARB_RD_TIMEOUT_EN
    // RAM never answers: timeout after 15 wait cycles
    ram_respond = 1'b0;
    push_txn(1'b0, 1'b0, 8'h12, 8'h00, 1'b1);
    drive_req(1'b0, 1'b0, 8'h12, 8'h00);
    t0 = cyc;
    wait_ack(1'b0, ac);
    drop_req(1'b0);
    check_eq("tmo_lat", 32'(ac - t0), 32'd18);
    check_eq("tmo_rdata", 32'(rdata), 32'd0);
    check_eq("tmo_err", 32'(err), 32'd1);
    @(negedge clk);
    ram_respond = 1'b1;
    do_txn(1'b0, 1'b0, 8'h12, 8'h00);
    check_eq("post_tmo_err", 32'(err), 32'd0);
    check_eq("post_tmo_rdata", 32'(rdata), 32'hA5);
    @(negedge clk);
`endif

    // Mixed single-port traffic
    for (int i = 0; i < 12; i++) begin
      logic          p, w;
      logic [DW-1:0] a, d;
      p = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(8'h10, 8'h17));
      d = 8'($urandom_range(0, 255));
      do_txn(p, w, a, d);
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check_eq("cmd_q_drained", 32'(exp_cmd.size()), 32'd0);
    check_eq("ack_q_drained", 32'(exp_ack.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
